ramp_gen: RTL and testbench
===========================

RAMP_GEN -- requirements
Module: ramp_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 7, meaning the ramp value width in bits.
REQ-002 The module SHALL have parameter STEP_W, default 4, meaning the step input width in bits.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port enable, input, 1 bit: advance the ramp by one step per clock when 1.
REQ-006 The module SHALL have port mode, input, 2 bits: 00 up-wrap, 01 down-wrap, 10 up-saturate, 11 triangle.
REQ-007 The module SHALL have port step, input, STEP_W bits: unsigned increment per enabled cycle.
REQ-008 The module SHALL have ports lo and hi, input, WIDTH bits each: inclusive lower and upper ramp limits.
REQ-009 The module SHALL have ports load (input, 1 bit) and load_val (input, WIDTH bits): synchronous preset.
REQ-010 The module SHALL have port data_out, output, WIDTH bits: current ramp value, registered.
REQ-011 The module SHALL have port wrap, output, 1 bit: one-cycle pulse on every wrap or triangle turn-around.
REQ-012 The module SHALL have ports dir (output, 1 bit: 1 = rising) and at_limit (output, 1 bit: data_out==lo or data_out==hi).

Function
REQ-013 The module SHALL compute next-value arithmetic in WIDTH+1 bits so that no sum or difference overflows silently.
REQ-014 The module SHALL give load priority over enable: next data_out = load_val clamped to [lo,hi], wrap = 0, dir unchanged.
REQ-015 With enable = 0 and load = 0, the module SHALL hold data_out and dir, and drive wrap = 0.
REQ-016 On an enabled cycle with data_out outside [lo,hi], or with lo > hi, the module SHALL set next data_out = lo with wrap = 0.
REQ-017 Mode 00: next = data_out+step if that is <= hi, else lo with wrap = 1.
REQ-018 Mode 01: next = data_out-step if data_out >= lo+step, else hi with wrap = 1.
REQ-019 Mode 10: next = min(data_out+step, hi); wrap always 0; at hi the value holds.
REQ-020 Mode 11 rising: next = data_out+step if < hi, else hi with dir <= 0 and wrap = 1.
REQ-021 Mode 11 falling: next = data_out-step if > lo, else lo with dir <= 1 and wrap = 1.
REQ-022 With step = 0, the module SHALL hold data_out with wrap = 0 in every mode.
REQ-023 A mode, lo, hi or step change SHALL take effect on the next enabled edge with no flush cycle; dir is retained across mode changes.
REQ-024 The module SHALL force dir = 1 in modes 00 and 10 and dir = 0 in mode 01 on every enabled cycle.
REQ-025 The module SHALL drive at_limit combinationally from the registered data_out, lo and hi.

Reset
REQ-026 While reset = 0, the module SHALL asynchronously force data_out = 0, dir = 1 and wrap = 0, independent of clock.
REQ-027 Reset deassertion mid-ramp SHALL restart from 0; the first enabled cycle then applies REQ-016 if 0 < lo.

Configuration
REQ-028 Macro RAMP_GEN_TRIANGLE_EN defined: mode 11 SHALL behave per REQ-020/021.
REQ-029 Macro RAMP_GEN_TRIANGLE_EN undefined: mode 11 SHALL behave identically to mode 00, and the dir register SHALL be absent with dir tied per REQ-024 (mode 11 gives dir = 1).

Verification
REQ-030 WIDTH=7, mode 00, step 1, lo 0, hi 127, enable held 1 -> data_out 0,1,...,127,0; wrap = 1 only in the cycle data_out returns to 0.
REQ-031 Mode 01, step 3, lo 10, hi 20, load_val 20 -> 20,17,14,11,20 with one wrap pulse.
REQ-032 Mode 10, step 5, lo 0, hi 12 -> 0,5,10,12,12; at_limit = 1 from the first 12; wrap stays 0.
REQ-033 Mode 11 with macro, step 4, lo 2, hi 10, from load 2 -> 2,6,10,6,2,6; dir toggles at 10 and at 2 with wrap pulses; without macro -> 2,6,10,2 with wrap.
REQ-034 Mode 00 at data_out 50, hi changed to 40 -> next 0 (lo), wrap 0; reset pulsed low mid-ramp -> data_out 0 immediately, before any clock edge.
REQ-035 load and enable both 1 with load_val 200, WIDTH=8, hi 150 -> data_out 150, wrap 0; lo 30 > hi 20 -> data_out 30 on every enabled cycle.

Source files
------------

// File: rtl/ramp_gen.sv
// Programmable ramp generator: up-wrap, down-wrap, up-saturate and triangle sweeps between lo and hi.
// Define RAMP_GEN_TRIANGLE_EN to enable triangle mode (mode 11); otherwise mode 11 acts as up-wrap.
module ramp_gen #(
    parameter int WIDTH  = 7,
    parameter int STEP_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  data_out,
    output logic              wrap,
    output logic              dir,
    output logic              at_limit
);

    typedef enum logic [1:0] {
        M_UPW = 2'b00,
        M_DNW = 2'b01,
        M_UPS = 2'b10,
        M_TRI = 2'b11
    } mode_e;

    // One extra bit of headroom so sums and limit comparisons never overflow.
    logic [WIDTH:0]   d_x, lo_x, hi_x, st_x, sum, lo_p_st;
    logic [WIDTH-1:0] nxt_d;
    logic             nxt_w;
    logic             out_rng;
    mode_e            mode_eff;

    assign d_x     = {1'b0, data_out};
    assign lo_x    = {1'b0, lo};
    assign hi_x    = {1'b0, hi};
    assign st_x    = (WIDTH+1)'(step);
    assign sum     = d_x + st_x;
    assign lo_p_st = lo_x + st_x;
    assign out_rng = (data_out < lo) || (data_out > hi) || (lo > hi);

`ifdef RAMP_GEN_TRIANGLE_EN
    logic dir_q, nxt_dir;
    assign dir      = dir_q;
    assign mode_eff = mode_e'(mode);
`else
    assign dir      = (mode != M_DNW);
    assign mode_eff = (mode_e'(mode) == M_TRI) ? M_UPW : mode_e'(mode);
`endif

    always_comb begin
        nxt_d = data_out;
        nxt_w = 1'b0;
`ifdef RAMP_GEN_TRIANGLE_EN
        nxt_dir = dir_q;
`endif
        if (load) begin
            if (load_val < lo)      nxt_d = lo;
            else if (load_val > hi) nxt_d = hi;
            else                    nxt_d = load_val;
        end else if (enable) begin
`ifdef RAMP_GEN_TRIANGLE_EN
            if (mode_eff == M_DNW)      nxt_dir = 1'b0;
            else if (mode_eff != M_TRI) nxt_dir = 1'b1;
`endif
            if (out_rng) begin
                nxt_d = lo;
            end else if (step != '0) begin
                case (mode_eff)
                    M_DNW: begin
                        if (d_x >= lo_p_st) nxt_d = WIDTH'(d_x - st_x);
                        else begin
                            nxt_d = hi;
                            nxt_w = 1'b1;
                        end
                    end
                    M_UPS: nxt_d = (sum < hi_x) ? WIDTH'(sum) : hi;
`ifdef RAMP_GEN_TRIANGLE_EN
                    M_TRI: begin
                        // Turn-around lands exactly on the limit, never past it.
                        if (dir_q) begin
                            if (sum < hi_x) nxt_d = WIDTH'(sum);
                            else begin
                                nxt_d   = hi;
                                nxt_dir = 1'b0;
                                nxt_w   = 1'b1;
                            end
                        end else begin
                            if (d_x > lo_p_st) nxt_d = WIDTH'(d_x - st_x);
                            else begin
                                nxt_d   = lo;
                                nxt_dir = 1'b1;
                                nxt_w   = 1'b1;
                            end
                        end
                    end
`endif
                    default: begin
                        if (sum <= hi_x) nxt_d = WIDTH'(sum);
                        else begin
                            nxt_d = lo;
                            nxt_w = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            wrap     <= 1'b0;
        end else begin
            data_out <= nxt_d;
            wrap     <= nxt_w;
        end
    end

`ifdef RAMP_GEN_TRIANGLE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) dir_q <= 1'b1;
        else        dir_q <= nxt_dir;
    end
`endif

    assign at_limit = (data_out == lo) || (data_out == hi);

endmodule

// File: tb/tb_ramp_gen.sv
// Randomized + directed bench for ramp_gen against an integer reference model.
module tb_ramp_gen;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0, load = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] step = 4'd0;
    logic [6:0] lo = 7'd0, hi = 7'd127, load_val = 7'd0;
    logic [6:0] data_out;
    logic       wrap, dir, at_limit;

    logic       en8 = 1'b0, ld8 = 1'b0;
    logic [7:0] lo8 = 8'd0, hi8 = 8'd255, lv8 = 8'd0, out8;
    logic       w8, dir8, al8;

    int checks = 0, failures = 0;
    int md = 0;
    bit mdir = 1'b1, mwrap = 1'b0;

    ramp_gen dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .step(step),
        .lo(lo), .hi(hi), .load(load), .load_val(load_val),
        .data_out(data_out), .wrap(wrap), .dir(dir), .at_limit(at_limit)
    );

    ramp_gen #(.WIDTH(8), .STEP_W(4)) dut8 (
        .clock(clock), .reset(reset), .enable(en8), .mode(mode), .step(step),
        .lo(lo8), .hi(hi8), .load(ld8), .load_val(lv8),
        .data_out(out8), .wrap(w8), .dir(dir8), .at_limit(al8)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: next value from the rules, with plain signed integer arithmetic.
    task automatic model_next();
        int l = lo, h = hi, s = step, d = md, m = mode;
`ifndef RAMP_GEN_TRIANGLE_EN
        if (m == 3) m = 0;
`endif
        mwrap = 1'b0;
        if (load) begin
            md = (load_val < l) ? l : (load_val > h) ? h : int'(load_val);
        end else if (enable) begin
            if (m == 0 || m == 2) mdir = 1'b1;
            else if (m == 1) mdir = 1'b0;
            if (d < l || d > h || l > h) md = l;
            else if (s != 0) begin
                case (m)
                    0: if (d + s <= h) md = d + s; else begin md = l; mwrap = 1'b1; end
                    1: if (d - s >= l) md = d - s; else begin md = h; mwrap = 1'b1; end
                    2: md = (d + s < h) ? d + s : h;
                    default: begin
                        if (mdir) begin
                            if (d + s < h) md = d + s;
                            else begin md = h; mdir = 1'b0; mwrap = 1'b1; end
                        end else begin
                            if (d - s > l) md = d - s;
                            else begin md = l; mdir = 1'b1; mwrap = 1'b1; end
                        end
                    end
                endcase
            end
        end
    endtask

    function automatic bit exp_dir();
`ifdef RAMP_GEN_TRIANGLE_EN
        return mdir;
`else
        return mode != 2'b01;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_data"}, int'(data_out), md);
        chk({tag, "_wrap"}, int'(wrap), int'(mwrap));
        chk({tag, "_dir"}, int'(dir), int'(exp_dir()));
        chk({tag, "_alim"}, int'(at_limit), int'(md == lo || md == hi));
    endtask

    task automatic cycle(input string tag);
        model_next();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic run_seq(input string tag, input int exp_seq[$]);
        foreach (exp_seq[i]) begin
            cycle(tag);
            chk({tag, "_seq"}, int'(data_out), exp_seq[i]);
            load = 1'b0;
        end
    endtask

    initial begin
        int nw;
        #12;
        check_all("reset");
        chk("reset_dir_const", int'(dir), 1);
        reset = 1'b1;

        // Full-range up-wrap at WIDTH=7
        @(negedge clock);
        mode = 2'b00; step = 4'd1; lo = 7'd0; hi = 7'd127; enable = 1'b1;
        nw = 0;
        for (int i = 1; i <= 128; i++) begin
            cycle("r030");
            if (wrap) nw++;
            if (i == 127) chk("r030_top", int'(data_out), 127);
        end
        chk("r030_ret0", int'(data_out), 0);
        chk("r030_wrap", int'(wrap), 1);
        chk("r030_nwrap", nw, 1);

        mode = 2'b01; step = 4'd3; lo = 7'd10; hi = 7'd20; load_val = 7'd20; load = 1'b1;
        run_seq("r031", '{20, 17, 14, 11, 20});
        chk("r031_wrap", int'(wrap), 1);

        mode = 2'b10; step = 4'd5; lo = 7'd0; hi = 7'd12; load_val = 7'd0; load = 1'b1;
        run_seq("r032", '{0, 5, 10, 12, 12});
        chk("r032_alim", int'(at_limit), 1);

        mode = 2'b11; step = 4'd4; lo = 7'd2; hi = 7'd10; load_val = 7'd2; load = 1'b1;
`ifdef RAMP_GEN_TRIANGLE_EN
        run_seq("r033", '{2, 6, 10, 6, 2, 6});
`else
        run_seq("r033", '{2, 6, 10, 2});
        chk("r033_wrap", int'(wrap), 1);
`endif

        mode = 2'b00; step = 4'd1; lo = 7'd0; hi = 7'd100; load_val = 7'd50; load = 1'b1;
        run_seq("r034a", '{50});
        hi = 7'd40;
        run_seq("r034b", '{0});
        chk("r034_wrap", int'(wrap), 0);
        hi = 7'd100;
        for (int i = 0; i < 5; i++) cycle("r034c");
        #2;
        reset = 1'b0;
        md = 0; mdir = 1'b1; mwrap = 1'b0;
        #1;
        chk("r034_async", int'(data_out), 0);
        check_all("r034_rst");
        #3;
        reset = 1'b1;

        // Load clamp and inverted limits on the 8-bit instance
        enable = 1'b0;
        @(negedge clock);
        lo8 = 8'd0; hi8 = 8'd150; lv8 = 8'd200; ld8 = 1'b1; en8 = 1'b1;
        cycle("r035a");
        chk("r035_clamp", int'(out8), 150);
        chk("r035_wrap", int'(w8), 0);
        ld8 = 1'b0; lo8 = 8'd30; hi8 = 8'd20;
        for (int i = 0; i < 3; i++) begin
            cycle("r035b");
            chk("r035_inv", int'(out8), 30);
        end
        en8 = 1'b0;

        // Random phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                int a = $urandom_range(0, 127), b = $urandom_range(0, 127);
                mode = 2'($urandom_range(0, 3));
                step = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) != 0 && a > b) begin int t = a; a = b; b = t; end
                lo = 7'(a); hi = 7'(b);
            end
            load = ($urandom_range(0, 9) == 0);
            load_val = 7'($urandom_range(0, 127));
            enable = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
